// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared constants for the external memory arbiter:
//   - FSM state encodings (MA_*)
//   - grant owner encoding (last-grant tracking for round-robin ties)
//   - LSB access size encodings (SIZE_B/H/W)
//   - default IO window base address
//   - helper mapping an access size to its byte count
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        MA_IDLE  = 3'd0,
        MA_IC_RD = 3'd1,
        MA_LS_RD = 3'd2,
        MA_LS_WR = 3'd3,
        MA_DONE  = 3'd4
    } ma_state_e;

    typedef enum logic {
        GNT_IC  = 1'b0,
        GNT_LSB = 1'b1
    } ma_grant_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [31:0] DEFAULT_IO_BASE = 32'h0003_0000;

    // Number of RAM byte cycles for an LSB access; the unused encoding is
    // treated as a word so a stray value can never produce a zero-length access.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_B:  n = 3'd1;
            SIZE_H:  n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Sole owner of the byte-wide external RAM/IO port. Arbitrates between the
// instruction cache (32-bit fetches) and the load/store buffer (1/2/4-byte
// loads and committed stores), serialises each access into byte cycles,
// reassembles read data little-endian and returns a one-cycle ready pulse.
//
// Ports:
//   clk_in, rst_in      clock, asynchronous active-high reset
//   rdy_in              global enable; all state holds while low
//   clr_in              pipeline flush; aborts reads, never stores
//   mem_din/mem_dout    RAM read byte (one cycle after address) / write byte
//   mem_a, mem_wr       RAM byte address and write strobe
//   io_buffer_full      IO output buffer back-pressure (stalls IO stores)
//   ic_*                icache fetch request/response
//   lsb_*               load/store buffer request/response
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(DEFAULT_IO_BASE)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clr_in,

    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,

    input  logic                  ic_valid,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_ready,
    output logic [31:0]           ic_data,

    input  logic                  lsb_valid,
    input  logic                  lsb_wr,
    input  logic [1:0]            lsb_size,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [31:0]           lsb_wdata,
    output logic                  lsb_ready,
    output logic [31:0]           lsb_rdata
);

    ma_state_e             state_q;
    ma_grant_e             last_grant_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           wdata_q;
    logic [2:0]            nbytes_q;
    // Reads: edges seen since the grant edge. Writes: bytes already issued.
    logic [2:0]            cnt_q;
    logic                  is_io_q;
    logic [31:0]           rd_buf_q;
    logic                  mem_wr_q;

    // mem_din keeps following mem_a while rdy_in is low, so the byte that was
    // on the bus when the stall began is parked here and used on resume.
    logic                  rdy_q;
    logic [7:0]            din_save_q;

    logic                  ic_req;
    logic                  lsb_req;
    logic                  grant_ic;
    logic                  grant_lsb;
    logic                  lsb_is_io;
    logic [2:0]            lsb_nbytes;
    logic [2:0]            cnt_inc;
    logic [1:0]            cap_idx;
    logic [7:0]            din_byte;
    logic [7:0]            wr_byte;
    logic [31:0]           rd_asm;
    logic [ADDR_WIDTH-1:0] rd_next_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;

    // Reads are not started under a flush; committed stores always are.
    assign ic_req  = ic_valid & ~clr_in;
    assign lsb_req = lsb_valid & (lsb_wr | ~clr_in);

    // On a tie the requester that did not win last time gets the port.
    assign grant_lsb = lsb_req & (~ic_req | (last_grant_q == GNT_IC));
    assign grant_ic  = ic_req & ~grant_lsb;

    assign lsb_is_io  = (lsb_addr >= IO_BASE);
    assign lsb_nbytes = size_to_bytes(lsb_size);

    assign cnt_inc      = cnt_q + 3'd1;
    assign cap_idx      = cnt_q[1:0] - 2'd1;
    assign din_byte     = rdy_q ? mem_din : din_save_q;
    assign rd_next_addr = base_q + ADDR_WIDTH'(cnt_inc);
    assign wr_addr      = base_q + ADDR_WIDTH'(cnt_q);
    assign wr_byte      = wdata_q[{cnt_q[1:0], 3'b000} +: 8];

    // Read word with the byte arriving this cycle merged in, so the final
    // byte and the ready pulse can be registered on the same edge.
    always_comb begin
        rd_asm = rd_buf_q;
        rd_asm[{cap_idx, 3'b000} +: 8] = din_byte;
    end

    assign mem_wr = mem_wr_q & rdy_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= MA_IDLE;
            last_grant_q <= GNT_IC;
            base_q       <= '0;
            wdata_q      <= '0;
            nbytes_q     <= '0;
            cnt_q        <= '0;
            is_io_q      <= 1'b0;
            rd_buf_q     <= '0;
            mem_wr_q     <= 1'b0;
            mem_a        <= '0;
            mem_dout     <= '0;
            ic_ready     <= 1'b0;
            lsb_ready    <= 1'b0;
            ic_data      <= '0;
            lsb_rdata    <= '0;
            rdy_q        <= 1'b1;
            din_save_q   <= '0;
        end else begin
            rdy_q <= rdy_in;
            if (!rdy_in && rdy_q) begin
                din_save_q <= mem_din;
            end

            if (rdy_in) begin
                unique case (state_q)
                    MA_IDLE: begin
                        if (grant_lsb) begin
                            last_grant_q <= GNT_LSB;
                            base_q       <= lsb_addr;
                            wdata_q      <= lsb_wdata;
                            nbytes_q     <= lsb_nbytes;
                            is_io_q      <= lsb_is_io;
                            rd_buf_q     <= '0;
                            if (lsb_wr) begin
                                state_q <= MA_LS_WR;
                                if (lsb_is_io && io_buffer_full) begin
                                    mem_wr_q <= 1'b0;
                                    cnt_q    <= 3'd0;
                                end else begin
                                    mem_a    <= lsb_addr;
                                    mem_dout <= lsb_wdata[7:0];
                                    mem_wr_q <= 1'b1;
                                    cnt_q    <= 3'd1;
                                end
                            end else begin
                                state_q  <= MA_LS_RD;
                                mem_a    <= lsb_addr;
                                mem_wr_q <= 1'b0;
                                cnt_q    <= 3'd0;
                            end
                        end else if (grant_ic) begin
                            last_grant_q <= GNT_IC;
                            state_q      <= MA_IC_RD;
                            base_q       <= ic_addr;
                            nbytes_q     <= 3'd4;
                            is_io_q      <= 1'b0;
                            rd_buf_q     <= '0;
                            mem_a        <= ic_addr;
                            mem_wr_q     <= 1'b0;
                            cnt_q        <= 3'd0;
                        end
                    end

                    MA_IC_RD, MA_LS_RD: begin
                        if (clr_in) begin
                            state_q  <= MA_IDLE;
                            mem_wr_q <= 1'b0;
                        end else begin
                            if (cnt_inc < nbytes_q) begin
                                mem_a <= rd_next_addr;
                            end
                            // Byte k arrives two edges after its address.
                            if (cnt_q != 3'd0) begin
                                rd_buf_q <= rd_asm;
                            end
                            if (cnt_q == nbytes_q) begin
                                state_q <= MA_DONE;
                                if (state_q == MA_IC_RD) begin
                                    ic_ready <= 1'b1;
                                    ic_data  <= rd_asm;
                                end else begin
                                    lsb_ready <= 1'b1;
                                    lsb_rdata <= rd_asm;
                                end
                            end
                            cnt_q <= cnt_inc;
                        end
                    end

                    MA_LS_WR: begin
                        if (cnt_q == nbytes_q) begin
                            mem_wr_q  <= 1'b0;
                            lsb_ready <= 1'b1;
                            state_q   <= MA_DONE;
                        end else if (is_io_q && io_buffer_full) begin
                            mem_wr_q <= 1'b0;
                        end else begin
                            mem_a    <= wr_addr;
                            mem_dout <= wr_byte;
                            mem_wr_q <= 1'b1;
                            cnt_q    <= cnt_inc;
                        end
                    end

                    MA_DONE: begin
                        ic_ready  <= 1'b0;
                        lsb_ready <= 1'b0;
                        state_q   <= MA_IDLE;
                    end

                    default: begin
                        state_q  <= MA_IDLE;
                        mem_wr_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the byte-wide external RAM/IO port.
- Shares that port between two requesters:
  - the instruction cache, which fetches 32-bit words for the instruction unit;
  - the load/store buffer, which performs 1/2/4-byte loads and committed stores.
- Serialises each access into per-byte RAM cycles, reassembles read data little-endian, and returns a one-cycle ready pulse to the requester.
- Honours pipeline flush (clr_in) and the IO output-buffer back-pressure signal.

Parameters:
- ADDR_WIDTH, 32, width of all addresses and of mem_a.
- IO_BASE, 32'h30000, any LSB access with address >= IO_BASE is an IO access.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  global enable; when low, all state holds
- clr_in  in  1  misprediction flush from the ROB
- mem_din  in  8  RAM read byte, valid the cycle after the RAM samples mem_a
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_WIDTH  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  IO output buffer full
- ic_valid  in  1  icache fetch request, held until ic_ready
- ic_addr  in  ADDR_WIDTH  fetch address, word-aligned
- ic_ready  out  1  one-cycle completion pulse
- ic_data  out  32  fetched word
- lsb_valid  in  1  LSB request, held until lsb_ready
- lsb_wr  in  1  1 = store, 0 = load
- lsb_size  in  2  0 = byte, 1 = half, 2 = word
- lsb_addr  in  ADDR_WIDTH  access address
- lsb_wdata  in  32  store data; low bytes used
- lsb_ready  out  1  one-cycle completion pulse
- lsb_rdata  out  32  load data, zero-extended; the LSB sign-extends

Behaviour:
- States: IDLE, IC_RD, LS_RD, LS_WR, DONE.
- Reset (asynchronous, immediate, no clock edge needed):
  - state=IDLE; last_grant=IC.
  - mem_a=0, mem_wr=0, mem_dout=0.
  - ic_ready=0, lsb_ready=0, ic_data=0, lsb_rdata=0.
- rdy_in low: every register holds; mem_wr is gated combinationally to 0.
- IDLE grant, sampled at edge E0:
  - Only one requester valid: grant it.
  - Both valid: grant the one that is not last_grant. After reset the first tie therefore goes to the LSB.
  - Update last_grant on every grant.
  - A read request seen together with clr_in is not granted. A store is granted regardless of clr_in.
- Byte count n: 4 for icache; 1, 2 or 4 for LSB by size.
- Reads (IC_RD, LS_RD):
  - After edge E(i), i=0..n-1: mem_a = addr + i, mem_wr = 0.
  - Byte i is captured from mem_din at edge E(i+2), into bits [8i+7:8i].
  - Ready pulse and data are registered at E(n+1). The state then goes to DONE.
  - Latency for a 4-byte read: ready is high in the 5th cycle after E0.
- Writes (LS_WR):
  - After edge E(i): mem_a = addr + i, mem_dout = wdata byte i, mem_wr = 1.
  - After the last byte, mem_wr drops and lsb_ready pulses at E(n). The state then goes to DONE.
- IO stores (addr >= IO_BASE):
  - While io_buffer_full=1, the store stalls before each byte: mem_wr=0, byte counter frozen.
  - It resumes the cycle after io_buffer_full falls.
- DONE:
  - Lasts exactly one cycle. The ready pulse is high only here, and nothing is granted in this cycle.
  - Next state is IDLE. This gives a one-cycle bubble, so the requester can drop valid before the next grant.
- clr_in during IC_RD or LS_RD:
  - Abort at the next edge: state goes to IDLE, no ready pulse, mem_wr=0, data registers unchanged.
  - clr_in in the DONE cycle does not retract the pulse already issued.
- clr_in during LS_WR: ignored. A committed store always completes.
- Requester dropping valid mid-transaction: ignored, the transaction runs to completion. Only clr_in aborts a read.
- Address arithmetic: wraps modulo 2^ADDR_WIDTH.
- Unaligned LSB addresses: legal, handled byte-by-byte.

Decomposition:
- Shared consts.v holds:
  - state encodings (MA_IDLE, MA_IC_RD, MA_LS_RD, MA_LS_WR, MA_DONE);
  - size encodings (SIZE_B, SIZE_H, SIZE_W);
  - default IO_BASE.
- Single flat module. No sub-module is warranted; the byte counter and assembly shifter are inline.

Test Plan:
- IC fetch:
  - Stimulus: ic_valid, ic_addr=0x100, RAM[0x100..0x103]=13,05,00,00.
  - Response: mem_a steps 0x100..0x103; ic_data=0x00000513 with ic_ready high for exactly 1 cycle, 5 cycles after grant; then 1 idle bubble.
- Tie then alternation:
  - Stimulus: ic_valid and an LSB LW to 0x200 both held, starting right after reset.
  - Response: LSB served first, IC second, LSB third; no requester starved.
- SW store:
  - Stimulus: SW to 0x1000, wdata=0xDEADBEEF.
  - Response: mem_wr=1 for exactly 4 cycles; mem_a=0x1000..0x1003; mem_dout=EF,BE,AD,DE; lsb_ready pulses once.
  - Variant: LH at 0x1001 after RAM preload returns 0x0000ADBE.
- IO back-pressure:
  - Stimulus: SB to 0x30000, data 0x41, io_buffer_full=1 for 3 cycles.
  - Response: mem_wr stays 0 throughout; mem_wr=1 with mem_dout=0x41 the cycle after full falls; then lsb_ready.
- Flush:
  - Stimulus: clr_in asserted while IC_RD is on byte 2.
  - Response: no ic_ready; IDLE next cycle.
  - Stimulus: clr_in during an SW.
  - Response: all 4 bytes written; lsb_ready still pulses.
- Reset/rdy:
  - Stimulus: rst_in asserted mid-store, between clock edges.
  - Response: mem_wr and mem_a go to 0 immediately.
  - Stimulus: rdy_in=0 for 2 cycles mid-read.
  - Response: state frozen; final data still correct.
